// File: rtl/display_arbiter.sv
// Shares the 4-digit display among a live background and three
// prioritised sources that each hold the display for HOLD_CYCLES.
module display_arbiter #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bg_data,
  input  logic [2:0]  req,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  input  logic [15:0] data3,
  output logic [15:0] big_bin,
  output logic [1:0]  owner,
  output logic        busy,
  output logic [2:0]  ack,
  output logic [2:0]  done
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state_q, state_d;
  logic [2:0]         pend_q, pend_d;
  logic [15:0]        pdata1, pdata2, pdata3;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        bin_d;
  logic [1:0]         owner_d;
  logic               busy_d;
  logic [2:0]         ack_d, done_d;
  logic [1:0]         top, gsel;
  logic               grant;
  logic [15:0]        gdata;

  function automatic logic [2:0] onehot(input logic [1:0] i);
    unique case (i)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  always_comb begin
    top = 2'd0;
    if (pend_q[2])      top = 2'd3;
    else if (pend_q[1]) top = 2'd2;
    else if (pend_q[0]) top = 2'd1;
  end

  always_comb begin
    gdata = pdata1;
    unique case (gsel)
      2'd2:    gdata = pdata2;
      2'd3:    gdata = pdata3;
      default: gdata = pdata1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = big_bin;
    owner_d = owner;
    busy_d  = busy;
    ack_d   = '0;
    done_d  = '0;
    grant   = 1'b0;
    gsel    = top;
    unique case (state_q)
      IDLE: begin
        bin_d   = bg_data;
        owner_d = 2'd0;
        busy_d  = 1'b0;
        grant   = (top != 2'd0);
      end
      HOLD: begin
        if (top > owner) begin
          done_d = onehot(owner);
          grant  = 1'b1;
        end else if ((pend_q & onehot(owner)) != 3'b000) begin
          gsel  = owner;
          grant = 1'b1;
        end else if (cnt_q == '0) begin
          done_d = onehot(owner);
          if (top != 2'd0) begin
            grant = 1'b1;
          end else begin
            state_d = IDLE;
            bin_d   = bg_data;
            owner_d = 2'd0;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant) begin
      state_d = HOLD;
      bin_d   = gdata;
      owner_d = gsel;
      busy_d  = 1'b1;
      ack_d   = onehot(gsel);
      cnt_d   = CNT_W'(HOLD_CYCLES - 1);
    end
    // a capture on the grant edge re-arms the source with the newer word
    pend_d = (pend_q & ~ack_d) | req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      pdata1  <= '0;
      pdata2  <= '0;
      pdata3  <= '0;
      cnt_q   <= '0;
      big_bin <= '0;
      owner   <= '0;
      busy    <= 1'b0;
      ack     <= '0;
      done    <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (req[0]) pdata1 <= data1;
      if (req[1]) pdata2 <= data2;
      if (req[2]) pdata3 <= data3;
      cnt_q   <= cnt_d;
      big_bin <= bin_d;
      owner   <= owner_d;
      busy    <= busy_d;
      ack     <= ack_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// Scoreboard bench for display_arbiter with a 4-cycle hold.
module tb_display_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bg_data, data1, data2, data3;
  logic [2:0]  req;
  logic [15:0] big_bin;
  logic [1:0]  owner;
  logic        busy;
  logic [2:0]  ack, done;

  display_arbiter #(.HOLD_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .bg_data(bg_data), .req(req),
    .data1(data1), .data2(data2), .data3(data3),
    .big_bin(big_bin), .owner(owner), .busy(busy),
    .ack(ack), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  r;
    logic [15:0] d1, d2, d3, bg;
    logic [24:0] e;
  } vec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [24:0] sb[$];
  logic [24:0] got, exp_v;

  assign got = {big_bin, owner, busy, ack, done};

  function automatic logic [24:0] o(input logic [15:0] bb,
      input logic [1:0] ow, input logic bz,
      input logic [2:0] ak, input logic [2:0] dn);
    return {bb, ow, bz, ak, dn};
  endfunction

  function automatic vec_t mk(input logic [2:0] r,
      input logic [15:0] d1, input logic [15:0] d2,
      input logic [15:0] d3, input logic [15:0] bg,
      input logic [24:0] e);
    vec_t v;
    v.r = r; v.d1 = d1; v.d2 = d2; v.d3 = d3; v.bg = bg; v.e = e;
    return v;
  endfunction

  // drive one cycle and queue the output expected after the edge
  task automatic step(input vec_t v);
    req = v.r; data1 = v.d1; data2 = v.d2; data3 = v.d3;
    bg_data = v.bg;
    sb.push_back(v.e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    vec_t t[$];
    rst_n = 1'b0; req = '0; bg_data = 16'h1234;
    data1 = '0; data2 = '0; data3 = '0;
    #12;
    n_cmp++;
    if (got !== 25'h0) begin
      n_err++;
      $display("FAIL reset_init got %h expected %h", got, 25'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    t.push_back(mk(3'b001, 16'hAAAA, 0, 0, 16'h1234, o(16'h1234, 0, 0, 0, 0)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'h1234, o(16'hAAAA, 1, 1, 3'b001, 0)));
    t.push_back(mk(3'b010, 0, 16'hBBBB, 0, 16'h1234, o(16'hAAAA, 1, 1, 0, 0)));
    foreach (t[i]) begin
      step(t[i]);
      exp_v = sb.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL reset_pre[%0d] got %h expected %h", i, got, exp_v);
      end
    end
    rst_n = 1'b0; req = '0;
    #1;
    n_cmp++;
    if (got !== 25'h0) begin
      n_err++;
      $display("FAIL reset_midhold got %h expected %h", got, 25'h0);
    end
    #2 rst_n = 1'b1;
    t.delete();
    t.push_back(mk(3'b000, 0, 0, 0, 16'h1234, o(16'h1234, 0, 0, 0, 0)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'h1234, o(16'h1234, 0, 0, 0, 0)));
    foreach (t[i]) begin
      step(t[i]);
      exp_v = sb.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL reset_post[%0d] got %h expected %h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_single;
    vec_t t[$];
    t.push_back(mk(3'b001, 16'hAAAA, 0, 0, 16'h5555, o(16'h5555, 0, 0, 0, 0)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'hAAAA, 1, 1, 3'b001, 0)));
    for (int k = 0; k < 3; k++)
      t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'hAAAA, 1, 1, 0, 0)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'h5555, 0, 0, 0, 3'b001)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'h5555, 0, 0, 0, 0)));
    foreach (t[i]) begin
      step(t[i]);
      exp_v = sb.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL single[%0d] got %h expected %h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_preempt;
    vec_t t[$];
    t.push_back(mk(3'b001, 16'h1111, 0, 0, 16'h5555, o(16'h5555, 0, 0, 0, 0)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'h1111, 1, 1, 3'b001, 0)));
    t.push_back(mk(3'b100, 0, 0, 16'hC0DE, 16'h5555, o(16'h1111, 1, 1, 0, 0)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'hC0DE, 3, 1, 3'b100, 3'b001)));
    for (int k = 0; k < 3; k++)
      t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'hC0DE, 3, 1, 0, 0)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'h5555, 0, 0, 0, 3'b100)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'h5555, 0, 0, 0, 0)));
    foreach (t[i]) begin
      step(t[i]);
      exp_v = sb.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL preempt[%0d] got %h expected %h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_waiting;
    vec_t t[$];
    t.push_back(mk(3'b011, 16'h2222, 16'h3333, 0, 16'h5555, o(16'h5555, 0, 0, 0, 0)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'h3333, 2, 1, 3'b010, 0)));
    for (int k = 0; k < 3; k++)
      t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'h3333, 2, 1, 0, 0)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'h2222, 1, 1, 3'b001, 3'b010)));
    for (int k = 0; k < 3; k++)
      t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'h2222, 1, 1, 0, 0)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'h5555, 0, 0, 0, 3'b001)));
    foreach (t[i]) begin
      step(t[i]);
      exp_v = sb.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL waiting[%0d] got %h expected %h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_restart;
    vec_t t[$];
    t.push_back(mk(3'b010, 0, 16'h7777, 0, 16'h5555, o(16'h5555, 0, 0, 0, 0)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'h7777, 2, 1, 3'b010, 0)));
    t.push_back(mk(3'b010, 0, 16'h0005, 0, 16'h5555, o(16'h7777, 2, 1, 0, 0)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'h0005, 2, 1, 3'b010, 0)));
    for (int k = 0; k < 3; k++)
      t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'h0005, 2, 1, 0, 0)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'h5555, 0, 0, 0, 3'b010)));
    // source 2 overwrites its waiting word twice while source 3 holds
    t.push_back(mk(3'b100, 0, 0, 16'h3333, 16'h5555, o(16'h5555, 0, 0, 0, 0)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'h3333, 3, 1, 3'b100, 0)));
    t.push_back(mk(3'b010, 0, 16'h0001, 0, 16'h5555, o(16'h3333, 3, 1, 0, 0)));
    t.push_back(mk(3'b010, 0, 16'h0002, 0, 16'h5555, o(16'h3333, 3, 1, 0, 0)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'h3333, 3, 1, 0, 0)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'h0002, 2, 1, 3'b010, 3'b100)));
    for (int k = 0; k < 3; k++)
      t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'h0002, 2, 1, 0, 0)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'h5555, 0, 0, 0, 3'b010)));
    foreach (t[i]) begin
      step(t[i]);
      exp_v = sb.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL restart[%0d] got %h expected %h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_same_edge;
    vec_t t[$];
    t.push_back(mk(3'b100, 0, 0, 16'h0003, 16'h5555, o(16'h5555, 0, 0, 0, 0)));
    t.push_back(mk(3'b100, 0, 0, 16'h0033, 16'h5555, o(16'h0003, 3, 1, 3'b100, 0)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'h0033, 3, 1, 3'b100, 0)));
    for (int k = 0; k < 3; k++)
      t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'h0033, 3, 1, 0, 0)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'h5555, 0, 0, 0, 3'b100)));
    foreach (t[i]) begin
      step(t[i]);
      exp_v = sb.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL same_edge[%0d] got %h expected %h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back;
    vec_t t[$];
    t.push_back(mk(3'b111, 16'h0001, 16'h0002, 16'h0003, 16'h5555, o(16'h5555, 0, 0, 0, 0)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'h0003, 3, 1, 3'b100, 0)));
    for (int k = 0; k < 3; k++)
      t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'h0003, 3, 1, 0, 0)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'h0002, 2, 1, 3'b010, 3'b100)));
    for (int k = 0; k < 3; k++)
      t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'h0002, 2, 1, 0, 0)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'h0001, 1, 1, 3'b001, 3'b010)));
    for (int k = 0; k < 3; k++)
      t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'h0001, 1, 1, 0, 0)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'h5555, o(16'h5555, 0, 0, 0, 3'b001)));
    foreach (t[i]) begin
      step(t[i]);
      exp_v = sb.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL back_to_back[%0d] got %h expected %h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_background;
    vec_t t[$];
    t.push_back(mk(3'b000, 0, 0, 0, 16'h0000, o(16'h0000, 0, 0, 0, 0)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'h0F0F, o(16'h0F0F, 0, 0, 0, 0)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'hF0F0, o(16'hF0F0, 0, 0, 0, 0)));
    t.push_back(mk(3'b001, 16'hABCD, 0, 0, 16'hF0F0, o(16'hF0F0, 0, 0, 0, 0)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'h1111, o(16'hABCD, 1, 1, 3'b001, 0)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'h2222, o(16'hABCD, 1, 1, 0, 0)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'h3333, o(16'hABCD, 1, 1, 0, 0)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'h4444, o(16'hABCD, 1, 1, 0, 0)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'h9999, o(16'h9999, 0, 0, 0, 3'b001)));
    t.push_back(mk(3'b000, 0, 0, 0, 16'h8888, o(16'h8888, 0, 0, 0, 0)));
    foreach (t[i]) begin
      step(t[i]);
      exp_v = sb.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL background[%0d] got %h expected %h", i, got, exp_v);
      end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_preempt;
    test_waiting;
    test_restart;
    test_same_edge;
    test_back_to_back;
    test_background;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
